// File: rtl/bcd_cascade_ctrl.sv
// bcd_cascade_ctrl: sequences NDIG single-digit BCD counters into one
// multi-digit up/down counter. It loads presets one digit per cycle and
// builds the ripple-free enable chain from the digit values. It also
// handles run/pause and pulses DONE (down count exhausted) or OVF (up wrap).
// Optional build macro: BCD_CASCADE_SATURATE_EN. When it is defined, an up
// count that reaches all-9s holds there and halts instead of wrapping.
module bcd_cascade_ctrl #(
  parameter int unsigned NDIG = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              STOP,
  input  logic              DIR,
  input  logic              TICK,
  input  logic              PRESET_VALID,
  output logic              PRESET_READY,
  input  logic [4*NDIG-1:0] PRESET,
  input  logic [4*NDIG-1:0] CNT_Q,
  output logic [NDIG-1:0]   CNT_ENABLE,
  output logic [NDIG-1:0]   CNT_LOAD,
  output logic              CNT_UP,
  output logic [3:0]        CNT_D,
  output logic              CNT_CLR,
  output logic              RUNNING,
  output logic              DONE,
  output logic              OVF
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic            dir_q, dir_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   preset_q, preset_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [NDIG-1:0] chain_en_c;
  logic            all_match_c;

  // Enable chain: digit i steps only when every lower digit sits at its rollover value
  always_comb begin
    logic run_ok;
    run_ok     = 1'b1;
    chain_en_c = '0;
    for (int i = 0; i < NDIG; i++) begin
      chain_en_c[i] = run_ok;
      run_ok        = run_ok & (CNT_Q[4*i +: 4] == (dir_q ? 4'd9 : 4'd0));
    end
    all_match_c = run_ok;
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    dir_d        = dir_q;
    idx_d        = idx_q;
    preset_d     = preset_q;
    done_d       = 1'b0;
    ovf_d        = 1'b0;
    PRESET_READY = 1'b0;
    CNT_ENABLE   = '0;
    CNT_LOAD     = '0;
    CNT_UP       = 1'b0;
    CNT_D        = 4'd0;
    RUNNING      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        PRESET_READY = 1'b1;
        if (PRESET_VALID) begin
          preset_d = PRESET;
          idx_d    = '0;
          ret_d    = state_q;
          state_d  = ST_LOAD;
        end else if (START && (state_q == ST_IDLE || !STOP)) begin
          dir_d   = DIR;
          state_d = ST_RUN;
        end
      end

      ST_LOAD: begin
        CNT_LOAD[idx_q]   = 1'b1;
        CNT_ENABLE[idx_q] = 1'b1;
        CNT_D             = preset_q[4*idx_q +: 4];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ret_q;
        end else begin
          idx_d = IW'(idx_q + 1'b1);
        end
      end

      ST_RUN: begin
        RUNNING = 1'b1;
        CNT_UP  = dir_q;
        if (STOP) begin
          state_d = ST_HALT;
        end else if (TICK) begin
          if (all_match_c && !dir_q) begin
            // Down count exhausted: hold at zero instead of borrowing to 9s
            done_d  = 1'b1;
            state_d = ST_HALT;
          end else if (all_match_c && dir_q) begin
            ovf_d = 1'b1;
`ifdef BCD_CASCADE_SATURATE_EN
            state_d = ST_HALT;
`else
            CNT_ENABLE = chain_en_c;
`endif
          end else begin
            CNT_ENABLE = chain_en_c;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Clear overrides every output, including in the middle of a load
    if (CLR) begin
      PRESET_READY = 1'b1;
      CNT_ENABLE   = '0;
      CNT_LOAD     = '0;
      CNT_UP       = 1'b0;
      CNT_D        = 4'd0;
      RUNNING      = 1'b0;
    end
  end

  assign CNT_CLR = CLR;
  assign DONE    = done_q & ~CLR;
  assign OVF     = ovf_q & ~CLR;

  // State and datapath registers with synchronous clear
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      dir_q    <= 1'b1;
      idx_q    <= '0;
      preset_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      preset_q <= preset_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: doc/bcd_cascade_ctrl.md
Name: bcd_cascade_ctrl

Overview:
- Controller that sequences a cascade of NDIG single-digit BCD counters, each with ENABLE, LOAD, UP and D ports, into one multi-digit up/down counter.
- Handshaked preset loading: one digit is loaded per cycle, digit 0 first.
- Generates the per-digit enables from the digit values for ripple-free carry and borrow.
- Run/pause control with a terminal-count (DONE) pulse and a wrap (OVF) pulse.
- Sits between the front-panel control logic and the digit-counter array.

Parameters:
- NDIG, 4, number of BCD digits in the cascade (1..8); digit 0 is least significant.

Ports:
- CLK  in  1  system clock, posedge.
- CLR  in  1  synchronous active-high reset; also drives CNT_CLR.
- START  in  1  level; begin or resume counting.
- STOP  in  1  level; pause counting.
- DIR  in  1  count direction, 1=up, 0=down; sampled on START.
- TICK  in  1  count strobe; one digit-0 step per cycle it is high in RUN.
- PRESET_VALID  in  1  preset word offered.
- PRESET_READY  out  1  controller accepts a preset this cycle.
- PRESET  in  4*NDIG  BCD preset; [3:0] is digit 0.
- CNT_Q  in  4*NDIG  current digit values from the counters.
- CNT_ENABLE  out  NDIG  per-digit ENABLE.
- CNT_LOAD  out  NDIG  per-digit LOAD.
- CNT_UP  out  1  shared UP to all digits.
- CNT_D  out  4  shared load data.
- CNT_CLR  out  1  counter clear; equals CLR combinationally.
- RUNNING  out  1  high in RUN.
- DONE  out  1  one-cycle pulse: down count exhausted.
- OVF  out  1  one-cycle pulse: up count wrapped from all-9s.

Behaviour:
- FSM states: IDLE, LOAD, RUN, HALT.
- Reset (CLR, synchronous, active-high):
  - State goes to IDLE; direction register = 1; digit index = 0; preset register = 0.
  - All outputs 0 except PRESET_READY=1 and CNT_CLR=1 during CLR.
  - CLR has priority over every other input in every state, including mid-LOAD; a partial load is abandoned.
- IDLE:
  - PRESET_READY=1.
  - PRESET_VALID&PRESET_READY: capture PRESET, go to LOAD with index 0.
  - Otherwise, START: latch DIR, go to RUN.
  - Preset acceptance has priority over START.
- LOAD:
  - PRESET_READY=0.
  - Each cycle: CNT_LOAD[idx]=1, CNT_ENABLE[idx]=1, CNT_D=preset digit idx, all other bits 0.
  - Takes exactly NDIG cycles, then returns to the state it came from (IDLE or HALT).
  - START, STOP and TICK are ignored during LOAD.
  - Preset digits above 9 are passed through unchecked.
- RUN:
  - RUNNING=1; CNT_UP=direction register.
  - Enable chain, combinational from CNT_Q:
    - CNT_ENABLE[0]=TICK.
    - CNT_ENABLE[i]=TICK & (all digits j<i equal 9 if up, 0 if down).
  - Counters update on the next edge, so the enable-to-Q latency is 1 cycle.
  - STOP: go to HALT, all enables 0 in that cycle; a TICK in that cycle is dropped. STOP wins over a simultaneous START.
  - Down, TICK, all digits 0:
    - Enables forced to 0, so no wrap to 9s.
    - DONE=1 in the next cycle.
    - Go to HALT.
  - Up, TICK, all digits 9:
    - Enables driven normally; every digit wraps to 0.
    - OVF=1 in the next cycle.
    - Stay in RUN.
- HALT:
  - Enables 0; PRESET_READY=1.
  - Preset accepted as in IDLE, returning to HALT after LOAD.
  - START with STOP low: re-latch DIR, go to RUN.
- DONE and OVF are registered, never high together, and each lasts exactly one cycle.

Optional Feature:
- Macro: BCD_CASCADE_SATURATE_EN.
- Defined: in up mode, TICK with all digits 9 forces enables to 0 (value holds at all-9s), pulses OVF next cycle, and goes to HALT.
- Undefined: wrap behaviour as described under Behaviour.
- DONE behaviour is the same in both builds.

Test Plan:
- CLR for 2 cycles from an arbitrary state -> IDLE, PRESET_READY=1, CNT_CLR=1 during CLR, all enables and loads 0, DONE=OVF=0.
- PRESET=0x1234 with VALID in IDLE:
  - 4 LOAD cycles: CNT_LOAD=0001/0010/0100/1000 with CNT_D=4,3,2,1.
  - Then IDLE, and counter model Q=1234.
- Preset 0x0199, START with DIR=1, one TICK -> CNT_ENABLE=0111 that cycle, then Q=0200; OVF=0.
- Preset 0x0002, DIR=0, START, TICK each cycle:
  - Q goes 0001, 0000.
  - On the third TICK: enables 0, DONE pulses 1 cycle, state HALT, Q stays 0000.
- Preset 0x9999, DIR=1, START, one TICK:
  - Default build: enables 1111, Q=0000, OVF pulse, still RUN.
  - With BCD_CASCADE_SATURATE_EN: enables 0000, Q=9999, OVF pulse, HALT.
- STOP, START and TICK together in RUN -> HALT, no enable asserted; then START alone -> RUN with the newly sampled DIR; CLR asserted mid-LOAD -> IDLE next cycle, no further CNT_LOAD.
